// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux with run-time selectable arbitration
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [SW-1:0]        sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [1:0] MODE_SEL  = 2'd0;
  localparam logic [1:0] MODE_PRIO = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;

  logic [SW-1:0]    rr_ptr;
  logic             load;
  logic             hit;
  logic [SW-1:0]    g;
  logic             grant;
  logic [WIDTH-1:0] g_data;

  // The output register can take a new word when empty or being drained this cycle.
  assign load  = ~out_valid | out_ready;
  assign grant = rst_n & load & hit;

  // Pick the candidate channel under the current mode; hold mode never hits.
  always_comb begin : arbitrate
    int idx;
    hit = 1'b0;
    g   = '0;
    idx = 0;
    case (mode)
      MODE_SEL: begin
        // sel values at or beyond N match no channel and so never grant.
        for (int i = 0; i < N; i++) begin
          if (!hit && sel == SW'(i) && in_valid[i]) begin
            hit = 1'b1;
            g   = SW'(i);
          end
        end
      end
      MODE_PRIO: begin
        for (int i = 0; i < N; i++) begin
          if (!hit && in_valid[i]) begin
            hit = 1'b1;
            g   = SW'(i);
          end
        end
      end
      MODE_RR: begin
        // Scan starting at rr_ptr, wrapping N-1 back to 0.
        for (int k = 0; k < N; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= N) idx = idx - N;
          if (!hit && in_valid[SW'(idx)]) begin
            hit = 1'b1;
            g   = SW'(idx);
          end
        end
      end
      default: begin
        hit = 1'b0;
      end
    endcase
  end

  // Decode the grant into a one-hot ready and select the winning word.
  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SW'(i)) g_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = grant && (g == SW'(i));
    end
  end

  // Output register: load on grant, otherwise empty out once the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_chan  <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the winner only on round-robin grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant && mode == MODE_RR) begin
      rr_ptr <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed vector bench for stream_mux_rr
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [1:0]  m3_sel;
  logic [23:0] m3_in_data;
  logic [2:0]  m3_in_ready;
  logic [7:0]  m3_out_data;
  logic [1:0]  m3_out_chan;
  logic        m3_out_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vq[$];

  assign in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  assign m3_in_data = {8'hA2, 8'hA1, 8'hA0};

  stream_mux_rr #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(2'd0), .sel(m3_sel),
    .in_data(m3_in_data), .in_valid(3'b111), .in_ready(m3_in_ready),
    .out_data(m3_out_data), .out_chan(m3_out_chan), .out_valid(m3_out_valid),
    .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [1:0] ch, input logic [7:0] d);
    chk({name, "_valid"}, out_valid, ov);
    chk({name, "_chan"}, out_chan, ch);
    chk({name, "_data"}, out_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // mode 0: direct select
    vq.push_back('{2'd0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2});
    vq.push_back('{2'd0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2});
    vq.push_back('{2'd0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    // mode 1: fixed priority, ch3 starved while ch1 valid
    vq.push_back('{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    vq.push_back('{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    vq.push_back('{2'd1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    // mode 2: round-robin from rr_ptr=0
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    // rr_ptr=2, in_valid=1001 -> ch3 then wrap to ch0
    vq.push_back('{2'd2, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    vq.push_back('{2'd2, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    // mode 3 drains, then round-robin resumes from rr_ptr=1
    vq.push_back('{2'd3, 2'd0, 4'hF,    1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0});
    vq.push_back('{2'd3, 2'd0, 4'hF,    1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2});
    // priority grant leaves rr_ptr at 3
    vq.push_back('{2'd1, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    vq.push_back('{2'd2, 2'd0, 4'hF,    1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});

    rst_n = 1'b0;
    mode = 2'd0;
    sel = 2'd0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    m3_sel = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 4'b0000);
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    in_valid = 4'h0;
    rst_n = 1'b1;

    // N=3 instance: sel beyond the last channel never grants
    m3_sel = 2'd3;
    #1 chk("n3_sel3_ready", m3_in_ready, 3'b000);
    m3_sel = 2'd2;
    #1 chk("n3_sel2_ready", m3_in_ready, 3'b100);
    m3_sel = 2'd0;
    #1 chk("n3_sel0_ready", m3_in_ready, 3'b001);

    @(posedge clk);
    #1;
    foreach (vq[j]) begin
      mode      = vq[j].mode;
      sel       = vq[j].sel;
      in_valid  = vq[j].valid;
      out_ready = vq[j].ordy;
      #1 chk($sformatf("v%0d_in_ready", j), in_ready, vq[j].exp_ir);
      @(posedge clk);
      #1 chk_out($sformatf("v%0d", j), vq[j].exp_ov, vq[j].exp_ch, vq[j].exp_d);
    end

    // Backpressure: ch3 word held, rr_ptr=0
    mode = 2'd2;
    in_valid = 4'hF;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_in_ready", c), in_ready, 4'b0000);
      @(posedge clk);
      #1 chk_out($sformatf("stall%0d", c), 1'b1, 2'd3, 8'hA3);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1 chk_out("release", 1'b1, 2'd0, 8'hA0);
    @(posedge clk);
    #1 chk_out("release_next", 1'b1, 2'd1, 8'hA1);

    // Asynchronous reset mid-cycle with a word held
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 2'd0, 8'h00);
    chk("async_reset_in_ready", in_ready, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset_in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1 chk_out("post_reset", 1'b1, 2'd0, 8'hA0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
